// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
//
// Byte-stream boot loader. It consumes a length-prefixed stream of
// (opcode, operand) byte pairs and writes one instruction per cycle-wide
// strobe into the program memory. The core is held off while the image is
// arriving and released when the image is complete.
//
// Stream format: LEN, then LEN pairs of (opcode, operand), then an optional
// checksum byte. LEN = 0 means 256 instructions.
//
// Build option:
//   LOADER_CHECKSUM_EN  when defined, a running XOR over LEN and every
//                       opcode/operand byte is compared with a trailing
//                       checksum byte. A mismatch parks the loader in ERR
//                       with the sticky load_err set. When undefined, the
//                       last operand leads straight to DONE and load_err
//                       is tied low.
//
// Parameters:
//   BASE_ADDR   program-memory address of the first instruction written
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   reload      single-cycle request to restart loading from any state
//   in_valid    stream byte present
//   in_data     stream byte
//   in_ready    loader accepts the byte this cycle
//   pm_we       program-memory write strobe, one cycle per instruction
//   pm_addr     program-memory write address
//   pm_opcode   opcode to write
//   pm_operand  operand to write
//   core_hold   holds fetch/execute while high (low only in DONE)
//   load_done   one-cycle pulse when the image is complete
//   load_err    sticky checksum-mismatch flag
//
// Handshake: a byte transfers on a rising edge where in_valid && in_ready
// are both high. The producer holds in_data stable while in_valid is high
// and in_ready is low. in_ready depends only on the loader state and on
// reload, never on in_valid, so there is no combinational loop through the
// producer.
// ---------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0] BASE_ADDR = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       reload,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       pm_we,
  output logic [7:0] pm_addr,
  output logic [7:0] pm_opcode,
  output logic [7:0] pm_operand,
  output logic       core_hold,
  output logic       load_done,
  output logic       load_err
);

`ifdef LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  // S_FIN covers the write-strobe cycle of the last instruction when no
  // checksum byte follows, so DONE (and load_done) lands on the edge after
  // that final pm_we cycle. With the checksum enabled, the CHK state plays
  // that role instead and the checksum byte may arrive during the last
  // pm_we cycle.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_OPC  = 3'd2,
    S_OPR  = 3'd3,
    S_FIN  = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;     // instructions still to be received
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  opc_q, opc_d;
  logic [7:0]  opr_q, opr_d;
  logic        we_q, we_d;
  logic        done_q, done_d;

  logic        accept;
  logic        chk_match;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      S_LEN, S_OPC, S_OPR, S_CHK: in_ready = 1'b1;
      default:                    in_ready = 1'b0;
    endcase
    // A reload wins over any byte offered in the same cycle.
    if (reload) begin
      in_ready = 1'b0;
    end
  end

  assign accept = in_valid && in_ready;

  // -------------------------------------------------------------------------
  // Optional checksum
  // -------------------------------------------------------------------------
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       err_q, err_d;

  always_comb begin
    xor_d = xor_q;
    if (state_q == S_IDLE) begin
      xor_d = 8'h00;
    end else if (accept && (state_q == S_LEN || state_q == S_OPC || state_q == S_OPR)) begin
      xor_d = xor_q ^ in_data;
    end
  end

  assign chk_match = (in_data == xor_q);

  always_comb begin
    err_d = err_q;
    if (reload) begin
      err_d = 1'b0;
    end else if (state_q == S_CHK && accept && !chk_match) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= 8'h00;
      err_q <= 1'b0;
    end else begin
      xor_q <= xor_d;
      err_q <= err_d;
    end
  end

  assign load_err = err_q;
`else
  assign chk_match = 1'b0;
  assign load_err  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    opc_d   = opc_q;
    opr_d   = opr_q;
    we_d    = 1'b0;
    done_d  = 1'b0;

    // The address is held through the strobe cycle and advances after it;
    // 8-bit arithmetic gives the FF -> 00 wrap for free.
    if (we_q) begin
      addr_d = addr_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_LEN;
      end

      S_LEN: begin
        if (accept) begin
          // LEN = 0 encodes 256: the zero test supplies bit 8.
          cnt_d   = {(in_data == 8'h00), in_data};
          state_d = S_OPC;
        end
      end

      S_OPC: begin
        if (accept) begin
          opc_d   = in_data;
          state_d = S_OPR;
        end
      end

      S_OPR: begin
        if (accept) begin
          opr_d = in_data;
          we_d  = 1'b1;
          cnt_d = cnt_q - 9'd1;
          if (cnt_q == 9'd1) begin
            state_d = CHK_EN ? S_CHK : S_FIN;
          end else begin
            state_d = S_OPC;
          end
        end
      end

      S_FIN: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end

      S_CHK: begin
        if (accept) begin
          if (chk_match) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end
      end

      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Restart from any state. A strobe already on the port this cycle still
    // completes (we_q is untouched); nothing new is launched.
    if (reload) begin
      state_d = S_IDLE;
      addr_d  = BASE_ADDR;
      we_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 9'd0;
      addr_q  <= BASE_ADDR;
      opc_q   <= 8'h00;
      opr_q   <= 8'h00;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      opc_q   <= opc_d;
      opr_q   <= opr_d;
      we_q    <= we_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pm_we      = we_q;
  assign pm_addr    = addr_q;
  assign pm_opcode  = opc_q;
  assign pm_operand = opr_q;
  assign load_done  = done_q;
  assign core_hold  = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam int CHK_BYTES = 1;
`else
  localparam int CHK_BYTES = 0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic reload;
  logic in_valid;
  logic [7:0] in_data;

  logic       in_ready_a, pm_we_a, core_hold_a, load_done_a, load_err_a;
  logic [7:0] pm_addr_a, pm_opcode_a, pm_operand_a;
  logic       in_ready_b, pm_we_b, core_hold_b, load_done_b, load_err_b;
  logic [7:0] pm_addr_b, pm_opcode_b, pm_operand_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(8'h00)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .pm_we(pm_we_a), .pm_addr(pm_addr_a), .pm_opcode(pm_opcode_a),
    .pm_operand(pm_operand_a), .core_hold(core_hold_a), .load_done(load_done_a),
    .load_err(load_err_a)
  );

  program_loader #(.BASE_ADDR(8'hFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .reload(reload), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .pm_we(pm_we_b), .pm_addr(pm_addr_b), .pm_opcode(pm_opcode_b),
    .pm_operand(pm_operand_b), .core_hold(core_hold_b), .load_done(load_done_b),
    .load_err(load_err_b)
  );

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  stim_q[$];
  logic [23:0] exp_a[$];
  logic [23:0] exp_b[$];
  logic [23:0] obs_a[$];
  logic [23:0] obs_b[$];
  int done_cnt_a = 0;
  int done_cyc_a = -1;
  int last_we_a  = -1;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every write strobe cycle and every load_done cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pm_we_a) begin
        obs_a.push_back({pm_addr_a, pm_opcode_a, pm_operand_a});
        last_we_a = cyc;
      end
      if (pm_we_b) obs_b.push_back({pm_addr_b, pm_opcode_b, pm_operand_b});
      if (load_done_a) begin
        done_cnt_a++;
        done_cyc_a = cyc;
      end
    end
  end

  // ---------------- reference model ----------------
  // Image semantics: instruction i goes to base+i (mod 256) with the i-th pair.
  function automatic void build_exp();
    int n;
    logic [7:0] ia;
    exp_a.delete();
    exp_b.delete();
    n = (stim_q[0] == 8'h00) ? 256 : int'(stim_q[0]);
    for (int i = 0; i < n; i++) begin
      ia = i[7:0];
      exp_a.push_back({8'h00 + ia, stim_q[1 + 2*i], stim_q[2 + 2*i]});
      exp_b.push_back({8'hFF + ia, stim_q[1 + 2*i], stim_q[2 + 2*i]});
    end
  endfunction

  function automatic void append_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    foreach (stim_q[i]) x = x ^ stim_q[i];
    stim_q.push_back(x);
`endif
  endfunction

  function automatic void make_random_image(input logic [7:0] len_byte);
    int n;
    stim_q.delete();
    stim_q.push_back(len_byte);
    n = (len_byte == 8'h00) ? 256 : int'(len_byte);
    for (int i = 0; i < 2*n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
    append_chk();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    reload   = 1'b1;
    in_valid = 1'b0;
    step();
    reload = 1'b0;
    obs_a.delete();
    obs_b.delete();
    done_cnt_a = 0;
    done_cyc_a = -1;
    last_we_a  = -1;
    step();
  endtask

  // gaps: 0 = one byte per cycle, 1 = in_valid every other cycle, 2 = random
  task automatic drive_stream(input int gaps);
    int idx = 0;
    int budget = 0;
    bit tog = 1'b0;
    bit acc;
    while (idx < stim_q.size() && budget < 4000) begin
      in_data = stim_q[idx];
      case (gaps)
        0:       in_valid = 1'b1;
        1:       in_valid = tog;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      acc = in_valid && in_ready_a;
      step();
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    vectors++;
    if (idx != stim_q.size()) begin
      miscompares++;
      $display("FAIL stream_timeout: accepted %0d bytes, want %0d", idx, stim_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; reload = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) step();
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready: got %0b want 0", in_ready_a); end
    vectors++; if (pm_we_a !== 1'b0) begin miscompares++; $display("FAIL rst_pm_we: got %0b want 0", pm_we_a); end
    vectors++; if (pm_addr_a !== 8'h00) begin miscompares++; $display("FAIL rst_addr_a: got %0h want 00", pm_addr_a); end
    vectors++; if (pm_addr_b !== 8'hFF) begin miscompares++; $display("FAIL rst_addr_b: got %0h want ff", pm_addr_b); end
    vectors++; if (pm_opcode_a !== 8'h00) begin miscompares++; $display("FAIL rst_opcode: got %0h want 00", pm_opcode_a); end
    vectors++; if (pm_operand_a !== 8'h00) begin miscompares++; $display("FAIL rst_operand: got %0h want 00", pm_operand_a); end
    vectors++; if (core_hold_a !== 1'b1) begin miscompares++; $display("FAIL rst_core_hold: got %0b want 1", core_hold_a); end
    vectors++; if (load_done_a !== 1'b0) begin miscompares++; $display("FAIL rst_load_done: got %0b want 0", load_done_a); end
    vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL rst_load_err: got %0b want 0", load_err_a); end
    rst_n = 1'b1;
    #1;
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL idle_ready: got %0b want 0", in_ready_a); end
    step();
    vectors++; if (in_ready_a !== 1'b1) begin miscompares++; $display("FAIL len_ready: got %0b want 1", in_ready_a); end
  endtask

  task automatic test_basic();
    int start;
    restart();
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h10); stim_q.push_back(8'h05);
    stim_q.push_back(8'h20); stim_q.push_back(8'h07);
    append_chk();
    build_exp();
    start = cyc;
    drive_stream(0);
    repeat (4) step();
    vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL basic_nwrites: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL basic_write%0d: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt_a); end
    vectors++; if (done_cyc_a != start + stim_q.size() + 1 - CHK_BYTES) begin miscompares++; $display("FAIL basic_done_cyc: got %0d want %0d", done_cyc_a - start, stim_q.size() + 1 - CHK_BYTES); end
    vectors++; if (done_cyc_a != last_we_a + 1) begin miscompares++; $display("FAIL basic_done_after_we: got %0d want %0d", done_cyc_a, last_we_a + 1); end
    vectors++; if (core_hold_a !== 1'b0) begin miscompares++; $display("FAIL basic_core_hold: got %0b want 0", core_hold_a); end
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL basic_done_ready: got %0b want 0", in_ready_a); end
    vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL basic_load_err: got %0b want 0", load_err_a); end
  endtask

  task automatic test_valid_toggle();
    restart();
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h10); stim_q.push_back(8'h05);
    stim_q.push_back(8'h20); stim_q.push_back(8'h07);
    append_chk();
    build_exp();
    drive_stream(1);
    repeat (4) step();
    vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL toggle_nwrites: got %0d want %0d", obs_a.size(), exp_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL toggle_write%0d: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL toggle_done_cnt: got %0d want 1", done_cnt_a); end
  endtask

  task automatic test_wrap();
    restart();
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'hAA); stim_q.push_back(8'h01);
    stim_q.push_back(8'hBB); stim_q.push_back(8'h02);
    append_chk();
    build_exp();
    drive_stream(0);
    repeat (4) step();
    vectors++; if (obs_b.size() != exp_b.size()) begin miscompares++; $display("FAIL wrap_nwrites: got %0d want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      vectors++; if (obs_b[i] !== exp_b[i]) begin miscompares++; $display("FAIL wrap_write%0d: got %h want %h", i, obs_b[i], exp_b[i]); end
    end
    vectors++; if (core_hold_b !== 1'b0) begin miscompares++; $display("FAIL wrap_core_hold: got %0b want 0", core_hold_b); end
  endtask

  task automatic test_len256();
    restart();
    make_random_image(8'h00);
    build_exp();
    drive_stream(0);
    repeat (4) step();
    vectors++; if (obs_a.size() != 256) begin miscompares++; $display("FAIL len256_nwrites: got %0d want 256", obs_a.size()); end
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
      vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL len256_write%0d: got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL len256_done_cnt: got %0d want 1", done_cnt_a); end
    vectors++; if (done_cyc_a != last_we_a + 1) begin miscompares++; $display("FAIL len256_done_cyc: got %0d want %0d", done_cyc_a, last_we_a + 1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      restart();
      make_random_image(8'($urandom_range(1, 12)));
      build_exp();
      drive_stream(2);
      repeat (4) step();
      vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL rand%0d_nwrites: got %0d want %0d", k, obs_a.size(), exp_a.size()); end
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
        vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL rand%0d_write%0d: got %h want %h", k, i, obs_a[i], exp_a[i]); end
      end
      for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
        vectors++; if (obs_b[i] !== exp_b[i]) begin miscompares++; $display("FAIL rand%0d_b_write%0d: got %h want %h", k, i, obs_b[i], exp_b[i]); end
      end
      vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL rand%0d_done_cnt: got %0d want 1", k, done_cnt_a); end
      vectors++; if (core_hold_a !== 1'b0) begin miscompares++; $display("FAIL rand%0d_core_hold: got %0b want 0", k, core_hold_a); end
    end
  endtask

  task automatic test_reload();
    restart();
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'hAA); stim_q.push_back(8'hBB);
    drive_stream(0);
    // Now in the first write-strobe cycle; the second opcode is offered with reload.
    in_data  = 8'hCC;
    in_valid = 1'b1;
    reload   = 1'b1;
    #1;
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL reload_ready: got %0b want 0", in_ready_a); end
    vectors++; if (pm_we_a !== 1'b1) begin miscompares++; $display("FAIL reload_we_pending: got %0b want 1", pm_we_a); end
    step();
    reload   = 1'b0;
    in_valid = 1'b0;
    vectors++; if (pm_opcode_a !== 8'hAA) begin miscompares++; $display("FAIL reload_opcode: got %0h want aa", pm_opcode_a); end
    vectors++; if (pm_addr_a !== 8'h00) begin miscompares++; $display("FAIL reload_addr: got %0h want 00", pm_addr_a); end
    vectors++; if (core_hold_a !== 1'b1) begin miscompares++; $display("FAIL reload_core_hold: got %0b want 1", core_hold_a); end
    vectors++; if (obs_a.size() != 1) begin miscompares++; $display("FAIL reload_we_completed: got %0d writes want 1", obs_a.size()); end
    else begin
      vectors++; if (obs_a[0] !== 24'h00AABB) begin miscompares++; $display("FAIL reload_first_write: got %h want 00aabb", obs_a[0]); end
    end
    obs_a.delete();
    obs_b.delete();
    done_cnt_a = 0;
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h33); stim_q.push_back(8'h44);
    append_chk();
    build_exp();
    drive_stream(0);
    repeat (4) step();
    vectors++; if (obs_a.size() != 1) begin miscompares++; $display("FAIL reload_nwrites: got %0d want 1", obs_a.size()); end
    else begin
      vectors++; if (obs_a[0] !== exp_a[0]) begin miscompares++; $display("FAIL reload_write: got %h want %h", obs_a[0], exp_a[0]); end
    end
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL reload_done_cnt: got %0d want 1", done_cnt_a); end
  endtask

  task automatic test_reset_midload();
    restart();
    stim_q.delete();
    stim_q.push_back(8'h02); stim_q.push_back(8'h5A); stim_q.push_back(8'hA5);
    drive_stream(0);
    vectors++; if (pm_we_a !== 1'b1) begin miscompares++; $display("FAIL midrst_we_before: got %0b want 1", pm_we_a); end
    rst_n = 1'b0;
    #1;
    vectors++; if (pm_we_a !== 1'b0) begin miscompares++; $display("FAIL midrst_we: got %0b want 0", pm_we_a); end
    vectors++; if (pm_addr_b !== 8'hFF) begin miscompares++; $display("FAIL midrst_addr: got %0h want ff", pm_addr_b); end
    vectors++; if (pm_opcode_a !== 8'h00) begin miscompares++; $display("FAIL midrst_opcode: got %0h want 00", pm_opcode_a); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_checksum();
`ifdef LOADER_CHECKSUM_EN
    restart();
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h12); stim_q.push_back(8'h34); stim_q.push_back(8'h27);
    drive_stream(0);
    repeat (3) step();
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL chk_good_done: got %0d want 1", done_cnt_a); end
    vectors++; if (core_hold_a !== 1'b0) begin miscompares++; $display("FAIL chk_good_hold: got %0b want 0", core_hold_a); end
    restart();
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h12); stim_q.push_back(8'h34); stim_q.push_back(8'h00);
    drive_stream(0);
    repeat (5) step();
    vectors++; if (load_err_a !== 1'b1) begin miscompares++; $display("FAIL chk_bad_err: got %0b want 1", load_err_a); end
    vectors++; if (core_hold_a !== 1'b1) begin miscompares++; $display("FAIL chk_bad_hold: got %0b want 1", core_hold_a); end
    vectors++; if (done_cnt_a != 0) begin miscompares++; $display("FAIL chk_bad_done: got %0d want 0", done_cnt_a); end
    vectors++; if (in_ready_a !== 1'b0) begin miscompares++; $display("FAIL chk_bad_ready: got %0b want 0", in_ready_a); end
    restart();
    vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL chk_reload_clears: got %0b want 0", load_err_a); end
`else
    // Without the checksum build, a byte that would be a checksum is refused
    // in DONE and the error flag never rises.
    restart();
    stim_q.delete();
    stim_q.push_back(8'h01); stim_q.push_back(8'h12); stim_q.push_back(8'h34);
    drive_stream(0);
    in_valid = 1'b1;
    in_data  = 8'h00;
    repeat (3) step();
    in_valid = 1'b0;
    vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL nochk_err: got %0b want 0", load_err_a); end
    vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL nochk_done: got %0d want 1", done_cnt_a); end
    vectors++; if (core_hold_a !== 1'b0) begin miscompares++; $display("FAIL nochk_hold: got %0b want 0", core_hold_a); end
`endif
  endtask

  task automatic test_back_to_back();
    int budget;
    for (int k = 0; k < 2; k++) begin
      restart();
      make_random_image(8'($urandom_range(2, 5)));
      build_exp();
      drive_stream(0);
      budget = 0;
      while (done_cnt_a == 0 && budget < 20) begin
        step();
        budget++;
      end
      vectors++; if (done_cnt_a != 1) begin miscompares++; $display("FAIL b2b%0d_done: got %0d want 1", k, done_cnt_a); end
      vectors++; if (obs_a.size() != exp_a.size()) begin miscompares++; $display("FAIL b2b%0d_nwrites: got %0d want %0d", k, obs_a.size(), exp_a.size()); end
      for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
        vectors++; if (obs_a[i] !== exp_a[i]) begin miscompares++; $display("FAIL b2b%0d_write%0d: got %h want %h", k, i, obs_a[i], exp_a[i]); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_valid_toggle();
    test_wrap();
    test_len256();
    test_random();
    test_reload();
    test_reset_midload();
    test_checksum();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
